ysyx_23060180_mem_bridge: RTL and testbench
===========================================

YSYX_23060180_MEM_BRIDGE -- requirements
Module: ysyx_23060180_mem_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data width in bits; legal values are 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, meaning request FIFO depth and maximum outstanding bus requests; power of 2, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have core-side inputs core_rd (1), core_wr (1), core_addr (ADDR_W), core_wdata (DATA_W) and core_wstrb (DATA_W/8): one-cycle request strobe plus its payload.
REQ-007 SHALL have core-side outputs core_stall (1), core_rdata (DATA_W) and core_rvalid (1): back-pressure, read data, and read-data valid pulse.
REQ-008 SHALL have bus request channel outputs req_valid (1), req_wr (1), req_addr (ADDR_W), req_wdata (DATA_W) and req_wstrb (DATA_W/8), plus input req_ready (1).
REQ-009 SHALL have bus response channel inputs rsp_valid (1), rsp_rdata (DATA_W) and rsp_err (1), plus output rsp_ready (1).
REQ-010 SHALL have outputs err_flag (1) and err_addr (ADDR_W): captured error status (see Configuration).

Function
REQ-011 SHALL push one entry {wr, addr, wdata, wstrb} into the request FIFO in each cycle where (core_rd | core_wr) is high and the FIFO is not full.
REQ-012 SHALL treat core_rd and core_wr asserted together as a single write.
REQ-013 SHALL drive core_stall = FIFO full, combinationally; a pop in the same cycle does not clear the stall, and a request presented while stalled is not captured.
REQ-014 SHALL drive req_valid when the FIFO is non-empty AND outstanding < DEPTH, presenting the FIFO head on the req_* payload ports.
REQ-015 SHALL pop the FIFO head and increment the outstanding count on the cycle where req_valid & req_ready.
REQ-016 SHALL keep the req_* payload stable while req_valid is high and req_ready is low.
REQ-017 SHALL record each issued request's read/write type in a DEPTH-entry in-order tag queue.
REQ-018 SHALL tie rsp_ready to 1 and accept one response per cycle with rsp_valid; responses are in issue order.
REQ-019 SHALL, on each response, pop the tag queue and decrement the outstanding count; if both issue and response occur in the same cycle, the count stays unchanged.
REQ-020 SHALL, for a read-tagged response at cycle M, register rsp_rdata into core_rdata and pulse core_rvalid high for exactly cycle M+1.
REQ-021 SHALL consume write-tagged responses silently, leaving core_rvalid low and core_rdata unchanged.
REQ-022 SHALL ignore rsp_valid when outstanding = 0, with no count underflow.
REQ-023 SHALL give a minimum latency of 1 cycle from core request to req_valid with the FIFO initially empty, and 1 cycle from rsp_valid to core_rvalid.
REQ-024 SHALL wrap FIFO and tag-queue pointers modulo DEPTH, using an extra MSB to distinguish full from empty.

Reset
REQ-025 SHALL, while rst is high, asynchronously empty the FIFO and tag queue, zero the outstanding count, and force core_stall, core_rvalid, req_valid, err_flag = 0 and core_rdata, err_addr = 0; rsp_ready remains 1.
REQ-026 SHALL, on reset asserted mid-transaction, discard all pending and outstanding requests; responses arriving after reset release are treated per REQ-022.

Configuration
REQ-027 SHALL, with macro YSYX_23060180_BRIDGE_ERR_EN defined, set err_flag sticky on the first response with rsp_err = 1 or the first response per REQ-022, and latch the matching request address into err_addr; cleared only by rst.
REQ-028 SHALL, without YSYX_23060180_BRIDGE_ERR_EN, ignore rsp_err and tie err_flag and err_addr to 0 with no error-capture storage.

Verification
REQ-029 SHALL cover single read: core_rd, addr 0x80000000, req_ready = 1, rsp 2 cycles later with rdata 0xDEADBEEF -> core_rvalid one cycle, core_rdata = 0xDEADBEEF.
REQ-030 SHALL cover fill: req_ready = 0 with 5 writes at DEPTH = 4 -> core_stall high after the 4th, the 5th not captured, and req_addr held stable.
REQ-031 SHALL cover outstanding limit: req_ready = 1, no responses, 6 reads -> exactly 4 handshakes; the 5th issues the cycle after the first response.
REQ-032 SHALL cover mixed order: write, read, write with responses rdata 0x1, 0x2, 0x3 -> exactly one core_rvalid, with core_rdata = 0x2.
REQ-033 SHALL cover error with ERR_EN: read of 0x1000 answered with rsp_err = 1 -> err_flag = 1, err_addr = 0x1000, persisting until rst; without ERR_EN both stay 0.
REQ-034 SHALL cover reset mid-flight: rst pulsed with 3 outstanding, then 2 stray rsp_valid -> no core_rvalid, count stays 0, and req_valid stays low.

Source files
------------

// File: rtl/ysyx_23060180_mem_bridge.sv
// Core-to-bus memory bridge: queues core requests, issues them with a bounded
// outstanding count, returns read data in order. Error capture: YSYX_23060180_BRIDGE_ERR_EN.
module ysyx_23060180_mem_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_rd,
  input  logic                core_wr,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_wstrb,
  output logic                core_stall,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                core_rvalid,
  output logic                req_valid,
  output logic                req_wr,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [DATA_W-1:0]   req_wdata,
  output logic [DATA_W/8-1:0] req_wstrb,
  input  logic                req_ready,
  input  logic                rsp_valid,
  input  logic [DATA_W-1:0]   rsp_rdata,
  input  logic                rsp_err,
  output logic                rsp_ready,
  output logic                err_flag,
  output logic [ADDR_W-1:0]   err_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = DATA_W / 8;
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [PW:0]       fifo_wptr;
  logic [PW:0]       fifo_rptr;
  logic              fifo_wr_q    [DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q  [DEPTH];
  logic [DATA_W-1:0] fifo_wdata_q [DEPTH];
  logic [SW-1:0]     fifo_wstrb_q [DEPTH];

  logic [PW:0]       tag_wptr;
  logic [PW:0]       tag_rptr;
  logic              tag_wr_q [DEPTH];

  logic [PW:0]       outstanding;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic fire;
  logic rsp_accept;
  logic rsp_is_read;

  // Extra pointer MSB tells a full ring from an empty one when the indices match.
  assign fifo_empty = (fifo_wptr == fifo_rptr);
  assign fifo_full  = (fifo_wptr[PW] != fifo_rptr[PW]) &&
                      (fifo_wptr[PW-1:0] == fifo_rptr[PW-1:0]);

  assign push       = (core_rd | core_wr) & ~fifo_full;
  assign core_stall = fifo_full;

  assign req_valid  = ~fifo_empty & ~outstanding[PW];
  assign req_wr     = fifo_wr_q[fifo_rptr[PW-1:0]];
  assign req_addr   = fifo_addr_q[fifo_rptr[PW-1:0]];
  assign req_wdata  = fifo_wdata_q[fifo_rptr[PW-1:0]];
  assign req_wstrb  = fifo_wstrb_q[fifo_rptr[PW-1:0]];
  assign fire       = req_valid & req_ready;

  assign rsp_ready   = 1'b1;
  assign rsp_accept  = rsp_valid & (outstanding != '0);
  assign rsp_is_read = rsp_accept & ~tag_wr_q[tag_rptr[PW-1:0]];

  // A simultaneous read and write strobe is stored as a write.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr_q[fifo_wptr[PW-1:0]]    <= core_wr;
      fifo_addr_q[fifo_wptr[PW-1:0]]  <= core_addr;
      fifo_wdata_q[fifo_wptr[PW-1:0]] <= core_wdata;
      fifo_wstrb_q[fifo_wptr[PW-1:0]] <= core_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      tag_wr_q[tag_wptr[PW-1:0]] <= fifo_wr_q[fifo_rptr[PW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wptr <= '0;
      fifo_rptr <= '0;
      tag_wptr  <= '0;
      tag_rptr  <= '0;
    end else begin
      if (push) begin
        fifo_wptr <= fifo_wptr + PTR_ONE;
      end
      if (fire) begin
        fifo_rptr <= fifo_rptr + PTR_ONE;
        tag_wptr  <= tag_wptr + PTR_ONE;
      end
      if (rsp_accept) begin
        tag_rptr <= tag_rptr + PTR_ONE;
      end
    end
  end

  // Never exceeds DEPTH, so its MSB alone marks the issue limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({fire, rsp_accept})
        2'b10:   outstanding <= outstanding + PTR_ONE;
        2'b01:   outstanding <= outstanding - PTR_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
    end else begin
      core_rvalid <= rsp_is_read;
      if (rsp_is_read) begin
        core_rdata <= rsp_rdata;
      end
    end
  end

`ifdef YSYX_23060180_BRIDGE_ERR_EN
  logic [ADDR_W-1:0] tag_addr_q [DEPTH];
  logic              err_hit;

  always_ff @(posedge clk) begin
    if (fire) begin
      tag_addr_q[tag_wptr[PW-1:0]] <= fifo_addr_q[fifo_rptr[PW-1:0]];
    end
  end

  // A stray response has no owning request, so it records address zero.
  assign err_hit = (rsp_accept & rsp_err) | (rsp_valid & ~rsp_accept);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (err_hit && !err_flag) begin
      err_flag <= 1'b1;
      err_addr <= rsp_accept ? tag_addr_q[tag_rptr[PW-1:0]] : '0;
    end
  end
`else
  logic unused_rsp_err;
  assign unused_rsp_err = rsp_err;
  assign err_flag       = 1'b0;
  assign err_addr       = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060180_mem_bridge.sv
// Self-checking bench for ysyx_23060180_mem_bridge: directed vector table, corner
// sequences and random traffic, all compared against a queue-based reference model.
module tb_ysyx_23060180_mem_bridge;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_rd, core_wr;
  logic [31:0] core_addr, core_wdata;
  logic [3:0]  core_wstrb;
  logic        core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        req_valid, req_wr, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_err, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        err_flag;
  logic [31:0] err_addr;

  ysyx_23060180_mem_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_wstrb(core_wstrb),
    .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .err_flag(err_flag), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rspv;
    logic [31:0] rdata;
    logic        e_req_valid;
    logic [31:0] e_req_addr;
    logic        e_rvalid;
    logic [31:0] e_rdata;
  } vec_t;

  // Reference model: requests waiting to issue, and issued requests awaiting a response.
  req_t        pend_q[$];
  req_t        out_q[$];
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_err_flag;
  logic [31:0] m_err_addr;

  int n_compared;
  int n_mismatched;
  int n_fires;
  int n_rvalid;
  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               input logic ready, input logic rspv,
                               input logic [31:0] rdata, input logic err);
    core_rd    = rd;
    core_wr    = wr;
    core_addr  = addr;
    core_wdata = wdata;
    core_wstrb = wstrb;
    req_ready  = ready;
    rsp_valid  = rspv;
    rsp_rdata  = rdata;
    rsp_err    = err;
  endtask

  task automatic idle(input logic ready);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ready, 1'b0, 32'h0, 1'b0);
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic rspv, input logic [31:0] rdata,
                              input logic erv, input logic [31:0] eaddr,
                              input logic ervld, input logic [31:0] erdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.rspv = rspv; v.rdata = rdata;
    v.e_req_valid = erv; v.e_req_addr = eaddr;
    v.e_rvalid = ervld; v.e_rdata = erdata;
    return v;
  endfunction

  // One clock: compare the DUT against the model mid-cycle, then advance the model.
  task automatic step();
    bit   exp_stall, exp_rv, fire, acc, stray, push;
    req_t nr;
    @(negedge clk);
    exp_stall = (pend_q.size() == DEPTH);
    exp_rv    = (pend_q.size() > 0) && (out_q.size() < DEPTH);
    checkOutput("core_stall", core_stall, exp_stall);
    checkOutput("req_valid", req_valid, exp_rv);
    if (exp_rv) begin
      checkOutput("req_wr", req_wr, pend_q[0].wr);
      checkOutput("req_addr", req_addr, pend_q[0].addr);
      checkOutput("req_wdata", req_wdata, pend_q[0].wdata);
      checkOutput("req_wstrb", req_wstrb, pend_q[0].wstrb);
    end
    checkOutput("core_rvalid", core_rvalid, m_rvalid);
    checkOutput("core_rdata", core_rdata, m_rdata);
    checkOutput("rsp_ready", rsp_ready, 1'b1);
    checkOutput("err_flag", err_flag, m_err_flag);
    checkOutput("err_addr", err_addr, m_err_addr);
    if (req_valid && req_ready) n_fires++;
    fire  = exp_rv && req_ready;
    acc   = rsp_valid && (out_q.size() > 0);
    stray = rsp_valid && (out_q.size() == 0);
    push  = (core_rd || core_wr) && !exp_stall;
    @(posedge clk);
    m_rvalid = 1'b0;
    if (acc && !out_q[0].wr) begin
      m_rvalid = 1'b1;
      m_rdata  = rsp_rdata;
    end
`ifdef YSYX_23060180_BRIDGE_ERR_EN
    if (!m_err_flag && ((acc && rsp_err) || stray)) begin
      m_err_flag = 1'b1;
      m_err_addr = acc ? out_q[0].addr : 32'h0;
    end
`else
    if (stray) m_rvalid = 1'b0;
`endif
    if (acc) void'(out_q.pop_front());
    if (fire) out_q.push_back(pend_q.pop_front());
    if (push) begin
      nr.wr    = core_wr;
      nr.addr  = core_addr;
      nr.wdata = core_wdata;
      nr.wstrb = core_wstrb;
      pend_q.push_back(nr);
    end
    #1;
  endtask

  task automatic doReset();
    #3;
    rst = 1'b1;
    idle(1'b0);
    pend_q.delete();
    out_q.delete();
    m_rvalid = 1'b0; m_rdata = 32'h0; m_err_flag = 1'b0; m_err_addr = 32'h0;
    #1;
    checkOutput("rst_req_valid", req_valid, 1'b0);
    checkOutput("rst_core_stall", core_stall, 1'b0);
    checkOutput("rst_core_rvalid", core_rvalid, 1'b0);
    checkOutput("rst_core_rdata", core_rdata, 32'h0);
    checkOutput("rst_err_flag", err_flag, 1'b0);
    checkOutput("rst_err_addr", err_addr, 32'h0);
    checkOutput("rst_rsp_ready", rsp_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_compared = 0; n_mismatched = 0; n_fires = 0; n_rvalid = 0;
    rst = 1'b1;
    idle(1'b0);
    doReset();

    // Single read then write/read/write with in-order responses.
    vecs[0]  = mk(1, 0, 32'h8000_0000, 0, 0, 0,            0, 0,            0, 0);
    vecs[1]  = mk(0, 0, 0, 0,            0, 0,            1, 32'h8000_0000, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0,            0, 0,            0, 0,            0, 0);
    vecs[3]  = mk(0, 0, 0, 0,            1, 32'hDEAD_BEEF, 0, 0,            0, 0);
    vecs[4]  = mk(0, 0, 0, 0,            0, 0,            0, 0,            1, 32'hDEAD_BEEF);
    vecs[5]  = mk(0, 0, 0, 0,            0, 0,            0, 0,            0, 32'hDEAD_BEEF);
    vecs[6]  = mk(0, 1, 32'h10, 32'hA,   0, 0,            0, 0,            0, 32'hDEAD_BEEF);
    vecs[7]  = mk(1, 0, 32'h20, 0,       0, 0,            1, 32'h10,       0, 32'hDEAD_BEEF);
    vecs[8]  = mk(0, 1, 32'h30, 32'hC,   0, 0,            1, 32'h20,       0, 32'hDEAD_BEEF);
    vecs[9]  = mk(0, 0, 0, 0,            0, 0,            1, 32'h30,       0, 32'hDEAD_BEEF);
    vecs[10] = mk(0, 0, 0, 0,            1, 32'h1,        0, 0,            0, 32'hDEAD_BEEF);
    vecs[11] = mk(0, 0, 0, 0,            1, 32'h2,        0, 0,            0, 32'hDEAD_BEEF);
    vecs[12] = mk(0, 0, 0, 0,            1, 32'h3,        0, 0,            1, 32'h2);
    vecs[13] = mk(0, 0, 0, 0,            0, 0,            0, 0,            0, 32'h2);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'hF, 1'b1,
                    vecs[i].rspv, vecs[i].rdata, 1'b0);
      #1;
      checkOutput($sformatf("vec%0d_req_valid", i), req_valid, vecs[i].e_req_valid);
      if (vecs[i].e_req_valid) checkOutput($sformatf("vec%0d_req_addr", i), req_addr, vecs[i].e_req_addr);
      checkOutput($sformatf("vec%0d_core_rvalid", i), core_rvalid, vecs[i].e_rvalid);
      checkOutput($sformatf("vec%0d_core_rdata", i), core_rdata, vecs[i].e_rdata);
      if (i >= 6 && core_rvalid) n_rvalid++;
      step();
    end
    checkOutput("mixed_rvalid_count", n_rvalid, 1);

    // Fill with the bus stalled: fifth write must be dropped.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'(i), 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput($sformatf("fill%0d_stall", i), core_stall, (i == 4) ? 1'b1 : 1'b0);
      if (i >= 1) checkOutput($sformatf("fill%0d_addr_hold", i), req_addr, 32'h100);
      step();
    end
    n_fires = 0;
    for (int i = 0; i < 6; i++) begin idle(1'b1); step(); end
    checkOutput("fill_drain_handshakes", n_fires, 4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, 1'b0);
      step();
    end
    idle(1'b1); step(); idle(1'b1);
    #1;
    checkOutput("fill_fifth_dropped", req_valid, 1'b0);
    step();

    // Outstanding limit: six reads, no responses, then release one slot.
    doReset();
    n_fires = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h200 + 32'(4 * i), 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
    end
    for (int i = 0; i < 4; i++) begin idle(1'b1); step(); end
    checkOutput("limit_handshakes", n_fires, 4);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h55, 1'b0);
    #1;
    checkOutput("limit_blocked", req_valid, 1'b0);
    step();
    idle(1'b1);
    #1;
    checkOutput("limit_reissue", req_valid, 1'b1);
    checkOutput("limit_reissue_addr", req_addr, 32'h210);
    step();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'($urandom), 1'b0);
      step();
    end

    // Random traffic, including stray responses and dual rd/wr strobes.
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 3) == 0, ($urandom % 4) == 0, 32'($urandom), 32'($urandom),
                    4'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0,
                    32'($urandom), ($urandom % 16) == 0);
      step();
    end

    // Error response on a read of 0x1000.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    idle(1'b1); step();
    idle(1'b1); step();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h77, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      #1;
`ifdef YSYX_23060180_BRIDGE_ERR_EN
      checkOutput($sformatf("err%0d_flag", i), err_flag, 1'b1);
      checkOutput($sformatf("err%0d_addr", i), err_addr, 32'h1000);
`else
      checkOutput($sformatf("err%0d_flag", i), err_flag, 1'b0);
      checkOutput($sformatf("err%0d_addr", i), err_addr, 32'h0);
`endif
      step();
    end

    // Reset with three reads outstanding, then stray responses.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
    end
    idle(1'b1); step();
    doReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'hBAD0 + 32'(i), 1'b0);
      #1;
      checkOutput($sformatf("stray%0d_req_valid", i), req_valid, 1'b0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      idle(1'b1);
      #1;
      checkOutput($sformatf("stray%0d_rvalid", i), core_rvalid, 1'b0);
      checkOutput($sformatf("stray%0d_idle_req_valid", i), req_valid, 1'b0);
      step();
    end
    applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    idle(1'b1);
    #1;
    checkOutput("post_reset_issue", req_valid, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin idle(1'b1); step(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
